// File: rtl/ser_add_pkg.sv
// ============================================================================
// Module      : ser_add_pkg
// Description : Shared FSM state encoding and default operand width for the
//               bit-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_ha.sv
// ============================================================================
// Module      : fa_ha
// Description : 1-bit full adder built from two half adders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_ha (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  assign w_s1 = a ^ b;
  assign w_c1 = a & b;
  assign s    = w_s1 ^ ci;
  assign w_c2 = w_s1 & ci;
  assign co   = w_c1 | w_c2;

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder, LSB first, one full-adder step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
  import ser_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_s;
  logic             fa_co;

  fa_ha u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        // Counter parks at zero after the last bit instead of wrapping.
        if (cnt_q == C_LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference is plain integer addition of the captured operands.
  task automatic do_add8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                         input string tag);
    logic [8:0] exp9;
    int e;
    exp9 = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    e = 0;
    while (done8 !== 1'b1 && e < 20) begin
      @(negedge clk);
      e++;
    end
    chk({tag, "_latency"}, e, 32'd8);
    chk({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp9[7:0]});
    chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp9[8]});
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {31'd0, done8}, 32'd0);
    chk({tag, "_sum_hold"}, {24'd0, sum8}, {24'd0, exp9[7:0]});
  endtask

  task automatic do_add4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
    logic [4:0] exp5;
    int e;
    exp5 = {1'b0, ta} + {1'b0, tb_} + {4'd0, tc};
    @(negedge clk);
    a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    e = 0;
    while (done4 !== 1'b1 && e < 12) begin
      @(negedge clk);
      e++;
    end
    chk("w4_latency", e, 32'd4);
    chk($sformatf("w4_%0h_%0h_%0h", ta, tb_, tc), {27'd0, cout4, sum4}, {27'd0, exp5});
  endtask

  initial begin
    int e;
    int ndone;
    logic [7:0] first_sum;
    int dq[$];

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    rst = 1'b0;

    // Directed corner cases
    do_add8(8'h00, 8'h00, 1'b0, "zero");
    do_add8(8'hFF, 8'h01, 1'b0, "ff_01");
    do_add8(8'hA5, 8'h5A, 1'b1, "a5_5a_c");
    do_add8(8'h7F, 8'h01, 1'b0, "7f_01");
    do_add8(8'hFF, 8'hFF, 1'b1, "ff_ff_c");

    // Random operands
    for (int i = 0; i < 20; i++)
      do_add8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    // Start during RUN is ignored
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; first_sum = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 3) begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1; end
      else start8 = 1'b0;
      if (done8 === 1'b1) begin
        if (ndone == 0) begin first_sum = sum8; chk("ign_latency", c, 32'd8); end
        ndone++;
      end
    end
    chk("ign_ndone", ndone, 32'd1);
    chk("ign_sum", {24'd0, first_sum}, 32'h46);

    // Reset aborts a run
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum", {24'd0, sum8}, 32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    do_add8(8'h03, 8'h04, 1'b0, "post_abort");

    // Start held high: back-to-back operations
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'hC4; cin8 = 1'b1; start8 = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        dq.push_back(c);
        chk("hold_sum", {23'd0, cout8, sum8}, 32'h101);
      end
    end
    start8 = 1'b0;
    chk("hold_ndone", dq.size(), 32'd4);
    if (dq.size() > 0) chk("hold_first", dq[0], 32'd8);
    for (int i = 1; i < dq.size(); i++)
      chk("hold_period", dq[i] - dq[i-1], 32'd10);
    e = 0;
    while ((busy8 !== 1'b0 || done8 !== 1'b0) && e < 15) begin
      @(negedge clk);
      e++;
    end
    chk("hold_drain", {31'd0, (busy8 === 1'b0 && done8 === 1'b0)}, 32'd1);

    // WIDTH=4 exhaustive
    for (int i = 0; i < 512; i++)
      do_add4(4'(i >> 5), 4'(i >> 1), 1'(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
